// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch/data arbiter onto one shared memory with a starvation
//               guard for fetches. Macro MEM_ARBITER_STATS_EN adds grant counters.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        im_req,
  input  logic [31:0] im_addr,
  output logic [31:0] im_rdata,
  output logic        im_ack,
  input  logic        dm_req,
  input  logic        dm_rd_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_access_size,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [1:0]  mem_access_size,
  output logic        mem_rd_wr,
`ifdef MEM_ARBITER_STATS_EN
  output logic [15:0] im_grant_cnt,
  output logic [15:0] dm_grant_cnt,
`endif
  output logic        mem_enable
);

  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] im_rdata_q, dm_rdata_q;
  logic        im_ack_q, dm_ack_q;
  logic        dm_rd_q;
  logic        grant_i, grant_d;

  // Grants are suppressed while reset is held so nothing is issued from reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (im_req && (!dm_req || starve_q == STARVE_LIM)) begin
        grant_i = 1'b1;
      end else if (dm_req) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_enable      = 1'b0;
    mem_addr        = 32'h0;
    mem_din         = 32'h0;
    mem_rd_wr       = 1'b1;
    mem_access_size = SZ_WORD;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          mem_enable = 1'b1;
          mem_addr   = im_addr;
          state_d    = RESP_I;
        end else if (grant_d) begin
          mem_enable      = 1'b1;
          mem_addr        = dm_addr;
          mem_din         = dm_wdata;
          mem_rd_wr       = dm_rd_wr;
          mem_access_size = dm_access_size;
          state_d         = RESP_D;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!im_req || grant_i) begin
      starve_d = 4'd0;
    end else if (grant_d && starve_q < STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      im_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      im_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
      dm_rd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      im_ack_q <= (state_q == RESP_I);
      dm_ack_q <= (state_q == RESP_D);
      if (grant_d) begin
        dm_rd_q <= dm_rd_wr;
      end
      if (state_q == RESP_I) begin
        im_rdata_q <= mem_dout;
      end
      // A store completes with an ack but leaves the load-data register alone.
      if (state_q == RESP_D && dm_rd_q) begin
        dm_rdata_q <= mem_dout;
      end
    end
  end

  assign im_ack   = im_ack_q;
  assign dm_ack   = dm_ack_q;
  assign im_rdata = im_rdata_q;
  assign dm_rdata = dm_rdata_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] im_cnt_q, dm_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_cnt_q <= 16'h0;
      dm_cnt_q <= 16'h0;
    end else begin
      if (grant_i && im_cnt_q != 16'hFFFF) begin
        im_cnt_q <= im_cnt_q + 16'd1;
      end
      if (grant_d && dm_cnt_q != 16'hFFFF) begin
        dm_cnt_q <= dm_cnt_q + 16'd1;
      end
    end
  end

  assign im_grant_cnt = im_cnt_q;
  assign dm_grant_cnt = dm_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : self-checking bench for mem_arbiter with a memory model
//                  and a transaction-level reference of the two requesters.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int WAIT_MAX   = 2 * (STARVE_MAX + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        im_req = 1'b0;
  logic [31:0] im_addr = 32'h0;
  logic [31:0] im_rdata;
  logic        im_ack;
  logic        dm_req = 1'b0;
  logic        dm_rd_wr = 1'b1;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [1:0]  dm_access_size = 2'b10;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = 32'h0;
  logic [1:0]  mem_access_size;
  logic        mem_rd_wr, mem_enable;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] im_grant_cnt, dm_grant_cnt;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_dm_rdata = 32'h0;
  logic [31:0] ref_mem [512];

  logic [31:0] env_mem [512];
  bit          env_vld [512] = '{default: 1'b0};

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .dm_req(dm_req), .dm_rd_wr(dm_rd_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_access_size(dm_access_size), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_access_size(mem_access_size), .mem_rd_wr(mem_rd_wr),
`ifdef MEM_ARBITER_STATS_EN
    .im_grant_cnt(im_grant_cnt), .dm_grant_cnt(dm_grant_cnt),
`endif
    .mem_enable(mem_enable)
  );

  function automatic int unsigned idx(input logic [31:0] a);
    return int'({a[28], a[9:2]});
  endfunction

  function automatic logic [31:0] init_word(input int unsigned i);
    logic [8:0] k;
    k = 9'(i);
    if (i == 0) return 32'h2408_0005;
    return {k, 7'h2B, ~k, 7'h51};
  endfunction

  // Memory environment: read data appears the cycle after the issue; other cycles carry junk.
  always @(posedge clk) begin
    if (mem_enable && mem_rd_wr)
      mem_dout <= env_vld[idx(mem_addr)] ? env_mem[idx(mem_addr)] : init_word(idx(mem_addr));
    else
      mem_dout <= $urandom;
    if (mem_enable && !mem_rd_wr) begin
      env_mem[idx(mem_addr)] <= mem_din;
      env_vld[idx(mem_addr)] <= 1'b1;
    end
  end

  task automatic test_reset();
    reset = 1'b1; im_req = 1'b1; dm_req = 1'b1;
    im_addr = 32'h0000_0100; dm_addr = 32'h1000_0000; dm_rd_wr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_enable !== 1'b0) begin n_err++; $display("FAIL reset_mem_enable: got %b want 0", mem_enable); end
    n_cmp++; if (mem_rd_wr !== 1'b1) begin n_err++; $display("FAIL reset_mem_rd_wr: got %b want 1", mem_rd_wr); end
    n_cmp++; if ({im_ack, dm_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b want 00", {im_ack, dm_ack}); end
    n_cmp++; if (im_rdata !== 32'h0) begin n_err++; $display("FAIL reset_im_rdata: got %h want 0", im_rdata); end
    n_cmp++; if (dm_rdata !== 32'h0) begin n_err++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); end
    dm_req = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_enable !== 1'b1 || mem_addr !== 32'h0000_0100)
      begin n_err++; $display("FAIL first_grant: got en=%b addr=%h want en=1 addr=00000100", mem_enable, mem_addr); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (im_ack !== 1'b1 || im_rdata !== init_word(64))
      begin n_err++; $display("FAIL first_fetch: got ack=%b data=%h want ack=1 data=%h", im_ack, im_rdata, init_word(64)); end
    im_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    im_addr = 32'h8002_0000; im_req = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_enable, mem_rd_wr, mem_access_size, mem_addr} !== {1'b1, 1'b1, 2'b10, 32'h8002_0000})
      begin n_err++; $display("FAIL fetch_issue: got en=%b rw=%b sz=%b addr=%h want 1 1 10 80020000", mem_enable, mem_rd_wr, mem_access_size, mem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (im_ack !== 1'b0 || mem_enable !== 1'b0)
      begin n_err++; $display("FAIL fetch_resp_cycle: got ack=%b en=%b want 0 0", im_ack, mem_enable); end
    @(posedge clk); #1;
    n_cmp++; if (im_ack !== 1'b1 || dm_ack !== 1'b0 || im_rdata !== 32'h2408_0005)
      begin n_err++; $display("FAIL fetch_ack: got ack=%b dack=%b data=%h want 1 0 24080005", im_ack, dm_ack, im_rdata); end
    im_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (im_ack !== 1'b0 || mem_enable !== 1'b0)
      begin n_err++; $display("FAIL fetch_pulse_end: got ack=%b en=%b want 0 0", im_ack, mem_enable); end
  endtask

  task automatic test_store();
    dm_addr = 32'h8002_0010; dm_wdata = 32'hDEAD_BEEF; dm_rd_wr = 1'b0; dm_req = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_enable, mem_rd_wr, mem_din, mem_addr} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 32'h8002_0010})
      begin n_err++; $display("FAIL store_issue: got en=%b rw=%b din=%h addr=%h want 1 0 deadbeef 80020010", mem_enable, mem_rd_wr, mem_din, mem_addr); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (dm_ack !== 1'b1 || im_ack !== 1'b0 || dm_rdata !== exp_dm_rdata)
      begin n_err++; $display("FAIL store_ack: got ack=%b iack=%b rdata=%h want 1 0 %h", dm_ack, im_ack, dm_rdata, exp_dm_rdata); end
    dm_rd_wr = 1'b1; dm_wdata = 32'h0;
    repeat (2) @(posedge clk); #1;
    exp_dm_rdata = 32'hDEAD_BEEF;
    n_cmp++; if (dm_ack !== 1'b1 || dm_rdata !== exp_dm_rdata)
      begin n_err++; $display("FAIL load_back: got ack=%b rdata=%h want 1 %h", dm_ack, dm_rdata, exp_dm_rdata); end
    dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_starve();
    byte got[$];
    int  run = 0;
    byte want;
    im_addr = 32'h8002_0020; dm_addr = 32'h8002_0040; dm_rd_wr = 1'b1;
    im_req = 1'b1; dm_req = 1'b1;
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      @(negedge clk);
      if (mem_enable) got.push_back((mem_addr === im_addr) ? "I" : "D");
      if (got.size() < 10) @(posedge clk);
    end
    repeat (2) @(posedge clk); #1;
    im_req = 1'b0; dm_req = 1'b0;
    exp_dm_rdata = init_word(16);
    @(posedge clk); #1;
    n_cmp++; if (got.size() != 10) begin n_err++; $display("FAIL starve_count: got %0d grants want 10", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      if (run == STARVE_MAX) begin want = "I"; run = 0; end
      else begin want = "D"; run++; end
      n_cmp++; if (got[k] != want) begin n_err++; $display("FAIL starve_grant%0d: got %s want %s", k, got[k], want); end
    end
  endtask

  task automatic test_reset_in_resp();
    dm_addr = 32'h8002_0040; dm_rd_wr = 1'b1; dm_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; dm_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({dm_ack, im_ack, mem_enable, mem_rd_wr} !== 4'b0001 || dm_rdata !== 32'h0 || im_rdata !== 32'h0)
      begin n_err++; $display("FAIL reset_in_resp: got dack=%b iack=%b en=%b rw=%b drd=%h ird=%h want 0 0 0 1 0 0", dm_ack, im_ack, mem_enable, mem_rd_wr, dm_rdata, im_rdata); end
    reset = 1'b0; exp_dm_rdata = 32'h0;
    @(posedge clk); #1;
    n_cmp++; if (dm_ack !== 1'b0) begin n_err++; $display("FAIL reset_late_ack: got %b want 0", dm_ack); end
    im_addr = 32'h8002_0000; im_req = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (im_ack !== 1'b1 || im_rdata !== 32'h2408_0005)
      begin n_err++; $display("FAIL post_reset_fetch: got ack=%b data=%h want 1 24080005", im_ack, im_rdata); end
    im_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          i_pend = 0, d_pend = 0, i_iss = 0, d_rd = 0;
    logic [31:0] i_a = 0, d_a = 0, d_w = 0;
    int          i_wait = 0, d_wait = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    for (int cyc = 0; cyc < 1100; cyc++) begin
      n_cmp++; if (im_ack && dm_ack) begin n_err++; $display("FAIL rand_overlap: cycle %0d both acks high", cyc); end
      if (im_ack) begin
        n_cmp++;
        if (!i_pend) begin n_err++; $display("FAIL rand_spurious_iack: cycle %0d", cyc); end
        else if (im_rdata !== ref_mem[idx(i_a)])
          begin n_err++; $display("FAIL rand_im_rdata: got %h want %h", im_rdata, ref_mem[idx(i_a)]); end
        i_pend = 0;
      end
      if (dm_ack) begin
        n_cmp++;
        if (!d_pend) begin n_err++; $display("FAIL rand_spurious_dack: cycle %0d", cyc); end
        else begin
          if (d_rd) exp_dm_rdata = ref_mem[idx(d_a)];
          else      ref_mem[idx(d_a)] = d_w;
          if (dm_rdata !== exp_dm_rdata)
            begin n_err++; $display("FAIL rand_dm_rdata: got %h want %h", dm_rdata, exp_dm_rdata); end
        end
        d_pend = 0;
      end
      if (i_pend && i_wait > 40) begin n_cmp++; n_err++; $display("FAIL rand_im_timeout: cycle %0d", cyc); i_pend = 0; end
      if (d_pend && d_wait > 40) begin n_cmp++; n_err++; $display("FAIL rand_dm_timeout: cycle %0d", cyc); d_pend = 0; end
      if (cyc < 1000 && !i_pend && $urandom_range(0, 99) < 45) begin
        i_pend = 1; i_iss = 0; i_wait = 0;
        i_a = 32'($urandom_range(64, 255)) << 2;
      end
      if (cyc < 1000 && !d_pend && $urandom_range(0, 99) < 60) begin
        d_pend = 1; d_wait = 0;
        d_a = 32'h1000_0000 | (32'($urandom_range(0, 63)) << 2);
        d_rd = ($urandom_range(0, 1) == 1);
        d_w = $urandom;
      end
      im_req = i_pend; im_addr = i_a;
      dm_req = d_pend; dm_addr = d_a; dm_rd_wr = d_rd; dm_wdata = d_w;
      dm_access_size = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (i_pend && !i_iss && mem_enable && mem_rd_wr && mem_addr === i_a) begin
        i_iss = 1;
        n_cmp++; if (i_wait > WAIT_MAX)
          begin n_err++; $display("FAIL rand_im_wait: got %0d cycles limit %0d", i_wait, WAIT_MAX); end
      end
      if (i_pend) i_wait++;
      if (d_pend) d_wait++;
      @(posedge clk); #1;
    end
    n_cmp++; if (i_pend || d_pend) begin n_err++; $display("FAIL rand_unacked: im=%b dm=%b want 0 0", i_pend, d_pend); end
    im_req = 1'b0; dm_req = 1'b0; dm_access_size = 2'b10;
    @(posedge clk); #1;
  endtask

`ifdef MEM_ARBITER_STATS_EN
  task automatic test_stats();
    int i_left = 3, d_left = 5;
    reset = 1'b1; im_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    n_cmp++; if (im_grant_cnt !== 16'd0 || dm_grant_cnt !== 16'd0)
      begin n_err++; $display("FAIL stats_reset: got %0d %0d want 0 0", im_grant_cnt, dm_grant_cnt); end
    im_addr = 32'h8002_0000; dm_addr = 32'h1000_0000; dm_rd_wr = 1'b1;
    for (int c = 0; c < 100 && (i_left > 0 || d_left > 0); c++) begin
      if (im_ack) i_left--;
      if (dm_ack) d_left--;
      im_req = (i_left > 0); dm_req = (d_left > 0);
      @(posedge clk); #1;
    end
    im_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (im_grant_cnt !== 16'd3 || dm_grant_cnt !== 16'd5)
      begin n_err++; $display("FAIL stats_counts: got %0d %0d want 3 5", im_grant_cnt, dm_grant_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_starve();
    test_reset_in_resp();
    test_random();
`ifdef MEM_ARBITER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
